// File: rtl/line_editor_pkg.sv
// Shared types and character constants for the AXI-Stream line editor.
// Case-swap helper is used only when LINE_EDITOR_CASE_INVERT_EN is defined.
package line_editor_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_EMIT_CR = 2'd2,
    ST_EMIT_LF = 2'd3
  } state_e;

  localparam logic [7:0] CHR_CR   = 8'h0D;
  localparam logic [7:0] CHR_LF   = 8'h0A;
  localparam logic [7:0] CHR_BS   = 8'h08;
  localparam logic [7:0] CHR_DEL  = 8'h7F;
  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

  // Letters differ from their other case only in bit 5.
  function automatic logic [7:0] case_swap(input logic [7:0] c);
    if (((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A)))
      return c ^ 8'h20;
    return c;
  endfunction

endpackage

// File: rtl/line_editor_ram.sv
// Line buffer storage: synchronous write, combinational read.
module line_editor_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i)
      mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/axis_line_editor.sv
// Collects an edited text line from an AXI-Stream byte source and replays it with CR LF.
// Optional case inversion of replayed text: define LINE_EDITOR_CASE_INVERT_EN.
module axis_line_editor
  import line_editor_pkg::*;
#(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       sresetn,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tlast,
  output logic [7:0] overflow_count,
  output logic       busy
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] rd_q, rd_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          wr_en;
  logic [7:0]    rd_data;
  logic [7:0]    emit_byte;
  logic          in_hs;
  logic          out_hs;

  line_editor_ram #(
    .DEPTH (MAX_LEN),
    .AW    (IW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (len_q[IW-1:0]),
    .wr_data_i (s_axis_tdata),
    .rd_addr_i (rd_q[IW-1:0]),
    .rd_data_o (rd_data)
  );

`ifdef LINE_EDITOR_CASE_INVERT_EN
  assign emit_byte = case_swap(rd_data);
`else
  assign emit_byte = rd_data;
`endif

  // Handshake outputs are held off while reset is asserted.
  assign s_axis_tready  = sresetn && (state_q == ST_COLLECT);
  assign m_axis_tvalid  = sresetn && (state_q != ST_COLLECT);
  assign m_axis_tlast   = sresetn && (state_q == ST_EMIT_LF);
  assign busy           = (state_q != ST_COLLECT);
  assign overflow_count = ovf_q;

  assign in_hs  = s_axis_tvalid && s_axis_tready;
  assign out_hs = m_axis_tvalid && m_axis_tready;

  always_comb begin
    case (state_q)
      ST_EMIT:    m_axis_tdata = emit_byte;
      ST_EMIT_CR: m_axis_tdata = CHR_CR;
      ST_EMIT_LF: m_axis_tdata = CHR_LF;
      default:    m_axis_tdata = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (in_hs) begin
          if (is_printable(s_axis_tdata)) begin
            if (len_q < LW'(MAX_LEN)) begin
              wr_en = 1'b1;
              len_d = len_q + LW'(1);
            end else if (ovf_q != 8'hFF) begin
              ovf_d = ovf_q + 8'd1;
            end
          end else if ((s_axis_tdata == CHR_BS) || (s_axis_tdata == CHR_DEL)) begin
            if (len_q != '0)
              len_d = len_q - LW'(1);
          end else if (s_axis_tdata == CHR_CR) begin
            rd_d    = '0;
            state_d = (len_q != '0) ? ST_EMIT : ST_EMIT_CR;
          end
        end
      end
      ST_EMIT: begin
        if (out_hs) begin
          rd_d = rd_q + LW'(1);
          if (rd_q == len_q - LW'(1))
            state_d = ST_EMIT_CR;
        end
      end
      ST_EMIT_CR: begin
        if (out_hs)
          state_d = ST_EMIT_LF;
      end
      ST_EMIT_LF: begin
        if (out_hs) begin
          len_d   = '0;
          rd_d    = '0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state_q <= ST_COLLECT;
      len_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_axis_line_editor.sv
// Scoreboard bench for axis_line_editor: queue-based line model feeds expected output bytes.
// Works with or without LINE_EDITOR_CASE_INVERT_EN defined.
module tb_axis_line_editor;

  localparam int MAXL = 6;

  logic       clk = 1'b0;
  logic       sresetn;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic [7:0] ovf;
  logic       busy;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] line_q[$];
  int         m_ovf;
  int         total;
  int         bad;
  int         ready_mode;
  int         allow_n;
  int         pop_cnt;

  axis_line_editor #(.MAX_LEN(MAXL)) dut (
    .clk            (clk),
    .sresetn        (sresetn),
    .s_axis_tvalid  (s_valid),
    .s_axis_tready  (s_ready),
    .s_axis_tdata   (s_data),
    .m_axis_tvalid  (m_valid),
    .m_axis_tready  (m_ready),
    .m_axis_tdata   (m_data),
    .m_axis_tlast   (m_last),
    .overflow_count (ovf),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_xform(input logic [7:0] c);
`ifdef LINE_EDITOR_CASE_INVERT_EN
    if (c >= "a" && c <= "z") return c - 8'd32;
    if (c >= "A" && c <= "Z") return c + 8'd32;
`endif
    return c;
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Line semantics: printable appends (or counts as overflow), BS/DEL erase, CR emits the line.
  task automatic model_accept(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      if (line_q.size() < MAXL) line_q.push_back(b);
      else if (m_ovf < 255) m_ovf++;
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (line_q.size() > 0) void'(line_q.pop_back());
    end else if (b == 8'h0D) begin
      foreach (line_q[i]) exp_q.push_back('{d: ref_xform(line_q[i]), l: 1'b0});
      exp_q.push_back('{d: 8'h0D, l: 1'b0});
      exp_q.push_back('{d: 8'h0A, l: 1'b1});
      line_q.delete();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!s_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      check("send_timeout", 1, 0);
    end else begin
      model_accept(b);
      @(posedge clk);
    end
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain_timeout"}, int'(t >= 3000), 0);
  endtask

  // Monitor: picks tready, then scores any handshake that the next rising edge will complete.
  initial begin : monitor
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, prev_rst = 1'b0;
    logic [7:0] prev_d = 8'h00;
    int         line_bytes = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = (allow_n > 0);
      endcase
      if (sresetn && prev_rst && prev_v && !prev_r) begin
        check("stall_valid", int'(m_valid), 1);
        check("stall_data", int'(m_data), int'(prev_d));
        check("stall_last", int'(m_last), int'(prev_l));
      end
      if (m_valid) check("s_ready_while_emitting", int'(s_ready), 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", int'(m_data), -1);
        end else begin
          e = exp_q.pop_front();
          pop_cnt++;
          line_bytes++;
          if (ready_mode == 2) allow_n--;
          check("out_data", int'(m_data), int'(e.d));
          check("out_last", int'(m_last), int'(e.l));
          if (e.l) begin
            $display("line emitted: %0d bytes (incl CR LF)", line_bytes);
            line_bytes = 0;
          end
        end
      end
      if (!sresetn) line_bytes = 0;
      prev_v   = m_valid;
      prev_r   = m_ready;
      prev_d   = m_data;
      prev_l   = m_last;
      prev_rst = sresetn;
    end
  end

  initial begin
    int t;
    int r;
    total      = 0;
    bad        = 0;
    m_ovf      = 0;
    ready_mode = 0;
    allow_n    = 0;
    pop_cnt    = 0;
    sresetn    = 1'b0;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    m_ready    = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_m_last", int'(m_last), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ovf", int'(ovf), 0);
    sresetn = 1'b1;
    @(negedge clk);
    check("idle_s_ready", int'(s_ready), 1);

    // Basic lines, editing, empty line, CR LF pair.
    send_str("abC"); send(8'h0D); drain("abC");
    send_str("ab"); send(8'h08); send_str("x"); send(8'h0D); drain("bs_edit");
    send(8'h08); send(8'h0D); drain("empty_line");
    send_str("q"); send(8'h0D); send(8'h0A); drain("cr_lf");
    check("lf_no_busy", int'(busy), 0);

    // Overflow and saturation.
    send_str("abcdefgh"); send(8'h0D); drain("ovf2");
    check("ovf_two", int'(ovf), 2);
    for (int i = 0; i < MAXL + 300; i++) send(8'h61 + 8'(i % 26));
    send(8'h0D); drain("ovf_sat");
    check("ovf_saturated", int'(ovf), 255);
    check("ovf_model", int'(ovf), m_ovf);

    // Stalled downstream.
    ready_mode = 1;
    send_str("Hello"); send(8'h0D); drain("hello_stall");

    // Random traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send(8'($urandom_range(32, 126)));
      else if (r < 80) send(8'h08);
      else if (r < 84) send(8'h7F);
      else if (r < 92) send(8'h0D);
      else if (r < 95) send(8'h0A);
      else             send(8'($urandom_range(128, 255)));
    end
    send(8'h0D); drain("random");
    check("random_ovf", int'(ovf), m_ovf);

    // Reset in the middle of emitting a 5-byte line.
    ready_mode = 2;
    allow_n    = 0;
    pop_cnt    = 0;
    send_str("abcde"); send(8'h0D);
    allow_n = 2;
    t = 0;
    while (pop_cnt < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("partial_emit_timeout", int'(t >= 200), 0);
    repeat (3) @(negedge clk);
    check("mid_emit_busy", int'(busy), 1);
    sresetn = 1'b0;
    exp_q.delete();
    line_q.delete();
    m_ovf = 0;
    #1;
    check("mid_rst_s_ready", int'(s_ready), 0);
    check("mid_rst_m_valid", int'(m_valid), 0);
    @(negedge clk);
    check("post_rst_m_valid", int'(m_valid), 0);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_ovf", int'(ovf), 0);
    sresetn    = 1'b1;
    ready_mode = 0;
    send_str("z"); send(8'h0D); drain("after_reset");
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_line_editor.md
AXIS_LINE_EDITOR -- requirements
Module: axis_line_editor

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, meaning maximum stored line length in bytes (range 2..1024).
REQ-002 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have port sresetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port s_axis_tvalid  input  1  input byte valid.
REQ-005 SHALL have port s_axis_tready  output  1  input byte accepted.
REQ-006 SHALL have port s_axis_tdata  input  8  input byte from the UART receive path.
REQ-007 SHALL have port m_axis_tvalid  output  1  output byte valid.
REQ-008 SHALL have port m_axis_tready  input  1  downstream (UART transmitter) ready.
REQ-009 SHALL have port m_axis_tdata  output  8  output byte.
REQ-010 SHALL have port m_axis_tlast  output  1  marks final byte (LF) of an emitted line.
REQ-011 SHALL have port overflow_count  output  8  saturating count of bytes dropped because the line was full.
REQ-012 SHALL have port busy  output  1  high whenever state is not COLLECT.

Function
REQ-013 SHALL implement states COLLECT, EMIT, EMIT_CR, EMIT_LF.
REQ-014 In COLLECT: s_axis_tready=1, m_axis_tvalid=0; in all other states: s_axis_tready=0.
REQ-015 Accepted printable byte (0x20..0x7E) with len<MAX_LEN SHALL be written to buf[len] and len incremented.
REQ-016 Accepted printable byte with len==MAX_LEN SHALL be dropped and overflow_count incremented, saturating at 255.
REQ-017 Accepted 0x08 or 0x7F SHALL decrement len if len>0; no effect at len==0.
REQ-018 Accepted 0x0D SHALL move to EMIT if len>0, else directly to EMIT_CR; rd index cleared to 0.
REQ-019 Accepted 0x0A and all other non-printable bytes in COLLECT SHALL be discarded with no state change.
REQ-020 EMIT: m_axis_tvalid=1, m_axis_tdata=xform(buf[rd]), tlast=0; on handshake rd increments; handshake at rd==len-1 moves to EMIT_CR.
REQ-021 EMIT_CR SHALL present 0x0D, tlast=0; on handshake move to EMIT_LF.
REQ-022 EMIT_LF SHALL present 0x0A, tlast=1; on handshake clear len and rd and return to COLLECT.
REQ-023 m_axis_tvalid SHALL assert the cycle after the terminating CR is accepted; tdata/tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-024 Sustained m_axis_tready=1 SHALL yield one output byte per cycle (line of N bytes emitted in N+2 cycles).
REQ-025 len and rd SHALL be $clog2(MAX_LEN+1) bits wide; len never exceeds MAX_LEN nor underflows.

Reset
REQ-026 With sresetn=0 at a clock edge: state=COLLECT, len=0, rd=0, overflow_count=0, m_axis_tvalid=0, m_axis_tlast=0, busy=0, s_axis_tready=0 during reset cycle.
REQ-027 Reset mid-EMIT SHALL abandon the line; buffer contents need not be cleared.

Configuration
REQ-028 Macro LINE_EDITOR_CASE_INVERT_EN defined: xform swaps ASCII case (0x41..0x5A ^0x20, 0x61..0x7A ^0x20), other bytes unchanged.
REQ-029 Macro undefined: xform is identity; all other behaviour identical.

Structure
REQ-030 Package line_editor_pkg SHALL hold state enum, character constants (CR, LF, BS, DEL, printable bounds) and the case-swap function.
REQ-031 Line storage SHALL be sub-module line_editor_ram (MAX_LEN x 8, sync write, combinational read); no other sub-modules.

Verification
REQ-032 "abC" CR, tready=1 -> output "ABc",0x0D,0x0A (tlast on 0x0A); with macro undefined -> "abC",0x0D,0x0A.
REQ-033 "ab",0x08,"x" CR -> "AX",0x0D,0x0A; 0x08 at len 0 then CR -> 0x0D,0x0A only.
REQ-034 MAX_LEN=4, "abcdef" CR -> "ABCD",0x0D,0x0A; overflow_count=2; 300 overflow bytes -> overflow_count=255.
REQ-035 m_axis_tready toggled randomly during "Hello" CR -> exact 7-byte sequence, tdata stable while stalled, s_axis_tready=0 throughout.
REQ-036 CR,LF pair after "q" -> single "Q",0x0D,0x0A; the LF is consumed silently.
REQ-037 sresetn pulsed while in EMIT after 2 of 5 bytes -> m_axis_tvalid=0 next cycle, busy=0, next line "z" CR -> "Z",0x0D,0x0A.
